// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - mux select/data and downstream word stream bundle
// The controller is the master: it drives select and the output stream.
interface mux_scan_ctrl_if #(
  parameter int BIT_WIDTH = 4,
  parameter int SEL_WIDTH = 2
);
  logic [SEL_WIDTH-1:0] select;
  logic [BIT_WIDTH-1:0] muxout;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output select,
    output out_data,
    output out_valid,
    input  muxout,
    input  out_ready
  );

  modport slave (
    input  select,
    input  out_data,
    input  out_valid,
    output muxout,
    output out_ready
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - ordered, back-pressure-aware scan of mux inputs
// Each word takes a SETUP cycle (mux settles on registered select) and a SEND cycle.
module mux_scan_ctrl #(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  mux_scan_ctrl_if.master     bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SEND  = 2'd2
  } state_e;

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] select_q, select_d;
  logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      select_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // abort beats a coincident start, so the scan never begins
        if (start && !abort) begin
          select_d = '0;
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        if (abort) begin
          state_d     = IDLE;
          select_d    = '0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          out_data_d  = bus.muxout;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end

      SEND: begin
        // an abort coinciding with the handshake discards that word
        if (abort) begin
          state_d     = IDLE;
          select_d    = '0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (select_q == LAST_SEL) begin
            select_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            select_d = select_q + 1'b1;
            state_d  = SETUP;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        select_d    = '0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign bus.select    = select_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl
// Instance a scans 4 inputs, instance b scans 3 of 4 inputs.
module tb_mux_scan_ctrl;

  logic clk;
  logic rst_n;
  logic start_a, abort_a, start_b, abort_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [15:0] data_a, data_b;

  int total = 0;
  int bad   = 0;

  mux_scan_ctrl_if #(.BIT_WIDTH(4), .SEL_WIDTH(2)) if_a ();
  mux_scan_ctrl_if #(.BIT_WIDTH(4), .SEL_WIDTH(2)) if_b ();

  mux_scan_ctrl #(.BIT_WIDTH(4), .DEPTH(4), .SEL_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .bus(if_a), .busy(busy_a), .done(done_a)
  );

  mux_scan_ctrl #(.BIT_WIDTH(4), .DEPTH(3), .SEL_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .bus(if_b), .busy(busy_b), .done(done_b)
  );

  // mux models: input0 in the LSBs
  assign if_a.muxout = data_a[{if_a.select, 2'b00} +: 4];
  assign if_b.muxout = data_b[{if_b.select, 2'b00} +: 4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] flags;   // start, abort, ready, exp valid, exp busy, exp done
    logic [1:0] sel;
    logic [3:0] data;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb_a[$];
  logic [5:0] sb_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] f, input logic [1:0] s, input logic [3:0] d);
    tbl.push_back({f, s, d});
  endtask

  task automatic chk_a(input string tag, input logic v, input logic b, input logic d,
                       input logic [1:0] s, input logic [3:0] dat);
    chk({tag, "_valid"}, 32'(if_a.out_valid), 32'(v));
    chk({tag, "_busy"},  32'(busy_a),         32'(b));
    chk({tag, "_done"},  32'(done_a),         32'(d));
    chk({tag, "_sel"},   32'(if_a.select),    32'(s));
    chk({tag, "_data"},  32'(if_a.out_data),  32'(dat));
  endtask

  // delivered-word monitors: a handshake completes on the coming rising edge
  always @(negedge clk) begin
    if (rst_n && if_a.out_valid && if_a.out_ready && !abort_a) begin
      if (sb_a.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_a_extra: got word %0h with no word expected", if_a.out_data);
      end else begin
        logic [5:0] e;
        e = sb_a.pop_front();
        chk("sb_a_sel",  32'(if_a.select),   32'(e[5:4]));
        chk("sb_a_data", 32'(if_a.out_data), 32'(e[3:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("b_sel_range", 32'(if_b.select != 2'd3), 32'd1);
      if (if_b.out_valid && if_b.out_ready && !abort_b) begin
        if (sb_b.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_b_extra: got word %0h with no word expected", if_b.out_data);
        end else begin
          logic [5:0] e;
          e = sb_b.pop_front();
          chk("sb_b_sel",  32'(if_b.select),   32'(e[5:4]));
          chk("sb_b_data", 32'(if_b.out_data), 32'(e[3:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       pv;
    logic [1:0] ps;
    logic [3:0] pd;
    int         cyc;

    rst_n = 1'b0; start_a = 1'b1; abort_a = 1'b0; if_a.out_ready = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; if_b.out_ready = 1'b1;
    data_a = 16'hA5C3; data_b = 16'hF321;

    // reset with start held
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    end
    rst_n = 1'b1; start_a = 1'b0;
    step();
    chk_a("post_rst", 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);

    // full scan with ignored starts, abort on a handshake, abort+start in IDLE, abort in SETUP
    add(6'b101_010, 2'd0, 4'h0);
    add(6'b001_110, 2'd0, 4'h3);
    add(6'b001_010, 2'd1, 4'h3);
    add(6'b101_110, 2'd1, 4'hC);
    add(6'b001_010, 2'd2, 4'hC);
    add(6'b101_110, 2'd2, 4'h5);
    add(6'b001_010, 2'd3, 4'h5);
    add(6'b001_110, 2'd3, 4'hA);
    add(6'b001_001, 2'd0, 4'hA);
    add(6'b001_000, 2'd0, 4'hA);
    add(6'b101_010, 2'd0, 4'hA);
    add(6'b001_110, 2'd0, 4'h3);
    add(6'b001_010, 2'd1, 4'h3);
    add(6'b001_110, 2'd1, 4'hC);
    add(6'b001_010, 2'd2, 4'hC);
    add(6'b001_110, 2'd2, 4'h5);
    add(6'b011_000, 2'd0, 4'h5);
    add(6'b111_000, 2'd0, 4'h5);
    add(6'b010_000, 2'd0, 4'h5);
    add(6'b101_010, 2'd0, 4'h5);
    add(6'b001_110, 2'd0, 4'h3);
    add(6'b001_010, 2'd1, 4'h3);
    add(6'b011_000, 2'd0, 4'h3);

    pv = 1'b0; ps = 2'd0; pd = 4'h0;
    foreach (tbl[i]) begin
      start_a        = tbl[i].flags[5];
      abort_a        = tbl[i].flags[4];
      if_a.out_ready = tbl[i].flags[3];
      if (pv && tbl[i].flags[3] && !tbl[i].flags[4]) sb_a.push_back({ps, pd});
      step();
      chk_a($sformatf("tbl%0d", i), tbl[i].flags[2], tbl[i].flags[1], tbl[i].flags[0],
            tbl[i].sel, tbl[i].data);
      pv = tbl[i].flags[2]; ps = tbl[i].sel; pd = tbl[i].data;
    end
    start_a = 1'b0; abort_a = 1'b0;

    // back-pressure on word 1 with mux data changing mid-stall
    data_a = 16'hA5C3; if_a.out_ready = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    chk_a("bp_w0", 1'b1, 1'b1, 1'b0, 2'd0, 4'h3);
    sb_a.push_back({2'd0, 4'h3});
    step();
    if_a.out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) data_a = 16'h0000;
      step();
      chk_a($sformatf("bp_stall%0d", k), 1'b1, 1'b1, 1'b0, 2'd1, 4'hC);
    end
    sb_a.push_back({2'd1, 4'hC});
    if_a.out_ready = 1'b1;
    step();
    step();
    chk_a("bp_w2", 1'b1, 1'b1, 1'b0, 2'd2, 4'h0);
    sb_a.push_back({2'd2, 4'h0});
    step();
    step();
    chk_a("bp_w3", 1'b1, 1'b1, 1'b0, 2'd3, 4'h0);
    sb_a.push_back({2'd3, 4'h0});
    step();
    chk_a("bp_done", 1'b0, 1'b0, 1'b1, 2'd0, 4'h0);

    // reset during word 1 SEND
    data_a = 16'hA5C3; start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    sb_a.push_back({2'd0, 4'h3});
    step();
    if_a.out_ready = 1'b0;
    step();
    chk_a("mr_w1", 1'b1, 1'b1, 1'b0, 2'd1, 4'hC);
    rst_n = 1'b0;
    step();
    chk_a("mr_rst", 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    rst_n = 1'b1; if_a.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_a($sformatf("mr_after%0d", k), 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    end

    // DEPTH=3 scan: select must stop at 2
    sb_b.push_back({2'd0, 4'h1});
    sb_b.push_back({2'd1, 4'h2});
    sb_b.push_back({2'd2, 4'h3});
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 20) begin
      step();
      cyc++;
    end
    chk("b_scan_cycles", 32'(cyc), 32'd6);
    chk("b_busy_end", 32'(busy_b), 32'd0);
    step();
    chk("b_done_pulse", 32'(done_b), 32'd0);

    chk("sb_a_left", 32'(sb_a.size()), 32'd0);
    chk("sb_b_left", 32'(sb_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
